// File: rtl/mac_check_pkg.sv
// Shared definitions for the MAC check block: FSM state encoding, default
// widths and a ceil-log2 helper for buffer pointer sizing.
package mac_check_pkg;

  localparam int DEF_MAC_WIDTH = 128;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMP  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_CMP  = ST_CMP,
    S_OUT  = ST_OUT
  } state_e;

  function automatic int log2c(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mac_check_fifo.sv
// Synchronous FIFO holding {tag, MAC} pairs in arrival order. The head entry is
// visible combinationally so a pop can load it the same cycle; no bypass path.
module mac_check_fifo
  import mac_check_pkg::*;
#(
  parameter int Width = DEF_MAC_WIDTH + 8,
  parameter int Depth = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (log2c(Depth) < 1) ? 1 : log2c(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge Clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mac_check.sv
// Pairs each computed hash with the next buffered expected MAC, compares the low
// MAC bits and reports a tagged pass/fail plus saturating violation statistics.
module mac_check
  import mac_check_pkg::*;
#(
  parameter int HashWidth = 512,
  parameter int MACWidth  = DEF_MAC_WIDTH,
  parameter int TagWidth  = 8,
  parameter int ExpDepth  = 4,
  parameter int CntWidth  = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 HashInValid,
  output logic                 HashInReady,
  input  logic [HashWidth-1:0] HashIn,
  input  logic                 ExpInValid,
  output logic                 ExpInReady,
  input  logic [MACWidth-1:0]  ExpMAC,
  input  logic [TagWidth-1:0]  ExpTag,
  output logic                 ResultValid,
  input  logic                 ResultReady,
  output logic                 ResultPass,
  output logic [TagWidth-1:0]  ResultTag,
  output logic [CntWidth-1:0]  ViolationCount,
  output logic                 IntegrityError
);

  localparam int EntryWidth = MACWidth + TagWidth;

  state_e                state_q, state_d;
  logic [MACWidth-1:0]   hash_q;
  logic [MACWidth-1:0]   mac_q;
  logic [TagWidth-1:0]   tag_q;
  logic                  pass_q;
  logic [TagWidth-1:0]   res_tag_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  err_q;

  logic [EntryWidth-1:0] fifo_head;
  logic                  fifo_full, fifo_empty;
  logic                  hash_fire, res_fire;

  mac_check_fifo #(
    .Width (EntryWidth),
    .Depth (ExpDepth)
  ) u_exp_fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .push_i  (ExpInValid),
    .data_i  ({ExpTag, ExpMAC}),
    .pop_i   (hash_fire),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  generate
    if (HashWidth > MACWidth) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^HashIn[HashWidth-1:MACWidth];
    end
  endgenerate

  assign ExpInReady = !fifo_full;
  assign hash_fire  = HashInValid && HashInReady;
  assign res_fire   = ResultValid && ResultReady;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (HashInValid && !fifo_empty) state_d = S_CMP;
      S_CMP:   state_d = S_OUT;
      S_OUT:   if (ResultReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    HashInReady = (state_q == S_IDLE) && !fifo_empty;
    ResultValid = (state_q == S_OUT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      hash_q    <= '0;
      mac_q     <= '0;
      tag_q     <= '0;
      pass_q    <= 1'b0;
      res_tag_q <= '0;
    end else begin
      if (hash_fire) begin
        hash_q <= HashIn[MACWidth-1:0];
        mac_q  <= fifo_head[MACWidth-1:0];
        tag_q  <= fifo_head[EntryWidth-1:MACWidth];
      end
      if (state_q == S_CMP) begin
        pass_q    <= (hash_q == mac_q);
        res_tag_q <= tag_q;
      end
    end
  end

  // Statistics advance only when a failing result is actually handed off.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (res_fire && !pass_q) begin
      err_q <= 1'b1;
      if (cnt_q != {CntWidth{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ResultPass     = pass_q;
  assign ResultTag      = res_tag_q;
  assign ViolationCount = cnt_q;
  assign IntegrityError = err_q;

endmodule

// File: tb/tb_mac_check.sv
// Self-checking bench for mac_check: directed scenarios plus randomized traffic
// against a queue-based reference model; a CntWidth=2 twin checks saturation.
module tb_mac_check;

  localparam int HW = 512;
  localparam int MW = 128;
  localparam int TW = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          HashInValid = 1'b0;
  logic [HW-1:0] HashIn = '0;
  logic          ExpInValid = 1'b0;
  logic [MW-1:0] ExpMAC = '0;
  logic [TW-1:0] ExpTag = '0;
  logic          ResultReady = 1'b0;

  logic          HashInReady, ExpInReady, ResultValid, ResultPass, IntegrityError;
  logic [TW-1:0] ResultTag;
  logic [15:0]   ViolationCount;

  logic          d2_hash_ready, d2_exp_ready, d2_res_valid, d2_res_pass, d2_err;
  logic [TW-1:0] d2_res_tag;
  logic [1:0]    d2_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [TW-1:0] tag;
    logic [MW-1:0] mac;
  } exp_t;
  exp_t   exp_q[$];
  longint vc_m;
  bit     ie_m;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  mac_check #(.HashWidth(HW), .MACWidth(MW), .TagWidth(TW), .ExpDepth(4), .CntWidth(16)) dut (
    .Clock(Clock), .Reset(Reset),
    .HashInValid(HashInValid), .HashInReady(HashInReady), .HashIn(HashIn),
    .ExpInValid(ExpInValid), .ExpInReady(ExpInReady), .ExpMAC(ExpMAC), .ExpTag(ExpTag),
    .ResultValid(ResultValid), .ResultReady(ResultReady), .ResultPass(ResultPass),
    .ResultTag(ResultTag), .ViolationCount(ViolationCount), .IntegrityError(IntegrityError)
  );

  mac_check #(.HashWidth(HW), .MACWidth(MW), .TagWidth(TW), .ExpDepth(4), .CntWidth(2)) dut2 (
    .Clock(Clock), .Reset(Reset),
    .HashInValid(HashInValid), .HashInReady(d2_hash_ready), .HashIn(HashIn),
    .ExpInValid(ExpInValid), .ExpInReady(d2_exp_ready), .ExpMAC(ExpMAC), .ExpTag(ExpTag),
    .ResultValid(d2_res_valid), .ResultReady(ResultReady), .ResultPass(d2_res_pass),
    .ResultTag(d2_res_tag), .ViolationCount(d2_count), .IntegrityError(d2_err)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [MW-1:0] rand_mac();
    logic [MW-1:0] m;
    for (int i = 0; i < MW / 32; i++) m[i*32 +: 32] = $urandom();
    return m;
  endfunction

  // Random upper bits, low bits equal to mac, optionally one low bit inverted.
  function automatic logic [HW-1:0] make_hash(input logic [MW-1:0] mac, input int flip);
    logic [HW-1:0] h;
    for (int i = 0; i < HW / 32; i++) h[i*32 +: 32] = $urandom();
    h[MW-1:0] = mac;
    if (flip >= 0) h[flip] = ~h[flip];
    return h;
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    HashInValid = 1'b0;
    ExpInValid = 1'b0;
    ResultReady = 1'b0;
    tick();
    Reset = 1'b0;
    exp_q.delete();
    vc_m = 0;
    ie_m = 1'b0;
  endtask

  task automatic push_exp(input logic [TW-1:0] tag, input logic [MW-1:0] mac);
    bit ok;
    int n;
    exp_t e;
    ExpInValid = 1'b1;
    ExpMAC = mac;
    ExpTag = tag;
    n = 0;
    do begin
      ok = ExpInReady;
      tick();
      n++;
    end while (!ok && n < 50);
    ExpInValid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: ExpInReady=%0b after %0d cycles, required 1", ExpInReady, n);
    end else begin
      e.tag = tag;
      e.mac = mac;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_hash(input logic [HW-1:0] h, output int hs_cyc);
    bit ok;
    int n;
    HashInValid = 1'b1;
    HashIn = h;
    n = 0;
    do begin
      ok = HashInReady;
      tick();
      n++;
    end while (!ok && n < 50);
    HashInValid = 1'b0;
    hs_cyc = cyc;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL hash_timeout: HashInReady=%0b after %0d cycles, required 1", HashInReady, n);
    end
  endtask

  // Pops the model head for the hash just sent, waits for and checks the result.
  task automatic get_result(input logic [HW-1:0] h, input int hs_cyc, input int stall);
    exp_t e;
    bit   pass_m;
    int   n;
    longint sat16, sat2;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL model_empty: hash sent with no expected MAC in model");
      return;
    end
    e = exp_q.pop_front();
    pass_m = (h[MW-1:0] == e.mac);
    n = 0;
    while (!ResultValid && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (cyc - hs_cyc + 1 !== 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles (valid=%0b), required 2", cyc - hs_cyc + 1, ResultValid);
    end
    checks++;
    if (ResultPass !== pass_m) begin
      errors++;
      $display("FAIL pass: got %0b, required %0b (tag %0h)", ResultPass, pass_m, e.tag);
    end
    checks++;
    if (ResultTag !== e.tag) begin
      errors++;
      $display("FAIL tag: got %0h, required %0h", ResultTag, e.tag);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if (ResultValid !== 1'b1 || ResultPass !== pass_m || ResultTag !== e.tag || HashInReady !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: valid=%0b pass=%0b tag=%0h hrdy=%0b, required 1 %0b %0h 0",
                 ResultValid, ResultPass, ResultTag, HashInReady, pass_m, e.tag);
      end
    end
    ResultReady = 1'b1;
    tick();
    ResultReady = 1'b0;
    if (!pass_m) begin
      vc_m++;
      ie_m = 1'b1;
    end
    sat16 = (vc_m > 65535) ? 65535 : vc_m;
    sat2  = (vc_m > 3) ? 3 : vc_m;
    checks++;
    if (ViolationCount !== 16'(sat16) || d2_count !== 2'(sat2)) begin
      errors++;
      $display("FAIL count: got %0d/%0d, required %0d/%0d", ViolationCount, d2_count, sat16, sat2);
    end
    checks++;
    if (IntegrityError !== ie_m || d2_err !== ie_m) begin
      errors++;
      $display("FAIL integrity: got %0b/%0b, required %0b", IntegrityError, d2_err, ie_m);
    end
    checks++;
    if (ResultValid !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: got %0b after handoff, required 0", ResultValid);
    end
    $display("txn tag=%02h pass=%0b exp_pass=%0b count=%0d sat2=%0d err=%0b",
             e.tag, ResultPass, pass_m, ViolationCount, d2_count, IntegrityError);
  endtask

  task automatic one_txn(input logic [TW-1:0] tag, input logic [MW-1:0] mac, input int flip, input int stall);
    logic [HW-1:0] h;
    int hs;
    push_exp(tag, mac);
    h = make_hash(mac, flip);
    send_hash(h, hs);
    get_result(h, hs, stall);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (HashInReady !== 1'b0 || ResultValid !== 1'b0 || ResultPass !== 1'b0 || ResultTag !== '0 ||
        ViolationCount !== '0 || IntegrityError !== 1'b0 || ExpInReady !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: hrdy=%0b rv=%0b rp=%0b rt=%0h vc=%0d ie=%0b erdy=%0b, required 0 0 0 0 0 0 1",
               HashInReady, ResultValid, ResultPass, ResultTag, ViolationCount, IntegrityError, ExpInReady);
    end
  endtask

  task automatic test_match();
    logic [MW-1:0] m;
    m = {16{8'hA5}};
    one_txn(8'h03, m, -1, 0);
  endtask

  task automatic test_mismatch();
    logic [MW-1:0] m;
    m = {16{8'hA5}};
    one_txn(8'h04, m, 0, 0);
    one_txn(8'h05, m, -1, 0);
  endtask

  task automatic test_fill_order();
    logic [HW-1:0] h;
    int hs;
    do_reset();
    for (int t = 1; t <= 4; t++) push_exp(TW'(t), rand_mac());
    checks++;
    if (ExpInReady !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: ExpInReady=%0b, required 0", ExpInReady);
    end
    for (int t = 1; t <= 4; t++) begin
      h = make_hash(exp_q[0].mac, -1);
      send_hash(h, hs);
      if (t == 1) begin
        checks++;
        if (ExpInReady !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_pop: ExpInReady=%0b, required 1", ExpInReady);
        end
      end
      get_result(h, hs, 0);
    end
  endtask

  task automatic test_empty_block();
    logic [MW-1:0] m;
    logic [HW-1:0] h;
    exp_t e;
    int hs;
    do_reset();
    m = rand_mac();
    h = make_hash(m, -1);
    HashInValid = 1'b1;
    HashIn = h;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (HashInReady !== 1'b0 || ResultValid !== 1'b0) begin
        errors++;
        $display("FAIL empty_block: hrdy=%0b rv=%0b at cycle %0d, required 0 0", HashInReady, ResultValid, i);
      end
    end
    ExpInValid = 1'b1;
    ExpMAC = m;
    ExpTag = 8'h7E;
    tick();
    ExpInValid = 1'b0;
    e.tag = 8'h7E;
    e.mac = m;
    exp_q.push_back(e);
    checks++;
    if (HashInReady !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_push: HashInReady=%0b, required 1", HashInReady);
    end
    tick();
    HashInValid = 1'b0;
    hs = cyc;
    get_result(h, hs, 0);
  endtask

  task automatic test_stall_reset();
    logic [MW-1:0] m;
    logic [HW-1:0] h;
    int hs;
    int n;
    do_reset();
    m = rand_mac();
    push_exp(8'h2C, m);
    h = make_hash(m, 77);
    send_hash(h, hs);
    for (int t = 0; t < 4; t++) push_exp(TW'(8'h40 + t), rand_mac());
    n = 0;
    while (!ResultValid && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ResultValid !== 1'b1 || ResultPass !== 1'b0 || ResultTag !== 8'h2C || HashInReady !== 1'b0) begin
        errors++;
        $display("FAIL stall5: rv=%0b rp=%0b rt=%0h hrdy=%0b, required 1 0 2c 0",
                 ResultValid, ResultPass, ResultTag, HashInReady);
      end
    end
    checks++;
    if (ExpInReady !== 1'b0) begin
      errors++;
      $display("FAIL prefull: ExpInReady=%0b, required 0", ExpInReady);
    end
    do_reset();
    checks++;
    if (ResultValid !== 1'b0 || ExpInReady !== 1'b1 || HashInReady !== 1'b0 || ViolationCount !== '0) begin
      errors++;
      $display("FAIL mid_reset: rv=%0b erdy=%0b hrdy=%0b vc=%0d, required 0 1 0 0",
               ResultValid, ExpInReady, HashInReady, ViolationCount);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) one_txn(TW'(8'h90 + i), rand_mac(), int'($urandom_range(0, MW - 1)), 0);
  endtask

  task automatic test_random();
    int kind;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 2));
      one_txn(TW'($urandom()), rand_mac(), (kind == 0) ? int'($urandom_range(0, MW - 1)) : -1,
              int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vc_m = 0;
    ie_m = 1'b0;
    test_reset();
    test_match();
    test_mismatch();
    test_fill_order();
    test_empty_block();
    test_stall_reset();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
